// File: rtl/bypass_arbiter_pkg.sv
// Shared definitions for the bypass arbiter: state encoding, the FSM idle code
// and the default counter width.
package bypass_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Output code of the shared Moore FSM when it has settled back to idle.
  localparam logic [1:0] FSM_IDLE_CODE = 2'b00;

  localparam int DEFAULT_CW = 4;

endpackage

// File: rtl/bypass_arbiter_rr_pick.sv
// Combinational circular priority select: first set request bit at or after ptr.
module bypass_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] sel_onehot,
  output logic [PW-1:0]      sel_idx
);

  logic          found;
  int            j;
  logic [PW-1:0] j_idx;

  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    found      = 1'b0;
    j          = 0;
    j_idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = PW'(j);
      if (!found && req[j_idx]) begin
        found             = 1'b1;
        sel_onehot[j_idx] = 1'b1;
        sel_idx           = j_idx;
      end
    end
  end

endmodule

// File: rtl/bypass_arbiter.sv
// Round-robin owner of the Moore FSM's bypass input: grant, hold window, drain.
// Optional drain timeout is compiled in with BYPASS_ARB_TIMEOUT_EN.
module bypass_arbiter
  import bypass_arbiter_pkg::*;
#(
  parameter int         NUM_REQ        = 4,
  parameter int         CW             = DEFAULT_CW,
  parameter logic [1:0] IDLE_CODE      = FSM_IDLE_CODE,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [CW-1:0]      hold_len,
  input  logic [1:0]         fsm_out,
  output logic               bypass,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic [CW-1:0]      load_len;
  logic [PW-1:0]      owner_next;
  logic               tmo_hit;
  logic               drain_exit;

  bypass_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) rr_pick (
    .req        (req),
    .ptr        (ptr),
    .sel_onehot (pick_onehot),
    .sel_idx    (pick_idx)
  );

  // A zero length still yields a one-cycle window.
  assign load_len   = (hold_len == '0) ? CW'(1) : hold_len;
  assign owner_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef BYPASS_ARB_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  logic [DW-1:0] dcnt;

  assign tmo_hit = (state == ST_DRAIN) && (fsm_out != IDLE_CODE) &&
                   (dcnt == DW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (state != ST_DRAIN)
        dcnt <= '0;
      else if (!tmo_hit)
        dcnt <= dcnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
  wire unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign drain_exit = (fsm_out == IDLE_CODE) || tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      bypass <= 1'b0;
      grant  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      ptr    <= '0;
      owner  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant  <= pick_onehot;
            owner  <= pick_idx;
            bypass <= 1'b1;
            cnt    <= load_len;
            busy   <= 1'b1;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(1)) begin
            bypass <= 1'b0;
            state  <= ST_DRAIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_exit) begin
            done  <= 1'b1;
            grant <= '0;
            ptr   <= owner_next;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          bypass <= 1'b0;
          grant  <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bypass_arbiter.md
Name: bypass_arbiter

Overview:
- Shares the single `bypass` input of the 4-state Moore FSM between NUM_REQ requesters.
- Arbitration is round-robin. Each winner gets one bypass window of programmable length.
- After the window, the block waits for the FSM output to return to its idle code before the next grant.
- Sits between requester logic and the FSM. It drives the FSM's `bypass` and observes the FSM's 2-bit `out`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CW, 4, width of hold_len and of the hold counter.
- IDLE_CODE, 2'b00, FSM output value meaning the FSM has settled back to idle.
- TIMEOUT_CYCLES, 16, drain timeout limit. Used only when BYPASS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester.
- hold_len  in  CW  bypass window length in cycles; sampled only at grant.
- fsm_out  in  2  the FSM's `out`.
- bypass  out  1  drives the FSM's `bypass`; registered.
- grant  out  NUM_REQ  one-hot owner of the current window; registered.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse when a window completes.
- timeout  out  1  one-cycle pulse on drain timeout; tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State IDLE.
  - bypass=0, grant=0, busy=0, done=0, timeout=0.
  - Round-robin pointer ptr=0.
  - Takes effect immediately; no window completes; no done pulse.
- States: IDLE, HOLD, DRAIN.
- IDLE:
  - If req != 0 at a rising edge, select the first set bit scanning circularly from ptr.
  - At that edge: grant=onehot(sel), bypass=1, load cnt=(hold_len==0 ? 1 : hold_len), go to HOLD.
  - Grant latency is 1 edge: req seen at edge N gives grant/bypass high from edge N onward.
- HOLD:
  - cnt decrements each edge.
  - When cnt==1 at an edge: bypass=0, go to DRAIN.
  - bypass is high for exactly max(hold_len,1) cycles.
  - req changes during HOLD are ignored; a requester dropping req does not shorten its window.
- DRAIN:
  - bypass=0, grant held.
  - When fsm_out==IDLE_CODE at an edge: done=1 for that cycle, grant=0, ptr=(sel+1) mod NUM_REQ, go to IDLE.
  - fsm_out already at IDLE_CODE on DRAIN entry completes at the first DRAIN edge, so DRAIN lasts a minimum of 1 cycle.
- Every window ends with at least one IDLE cycle before the next grant. There is no back-to-back grant, even with req held.
- req is level-sensitive. A requester still asserting req after done is re-arbitrated at its rotated priority.
- busy is a registered copy of (state != IDLE).
- grant is always zero or one-hot. bypass=1 implies grant != 0.
- hold_len values are unsigned; there is no wrap. Maximum window is 2^CW-1 cycles.

Optional Feature:
- Macro: BYPASS_ARB_TIMEOUT_EN.
- Defined:
  - A drain counter clears on DRAIN entry and counts DRAIN cycles.
  - If TIMEOUT_CYCLES DRAIN cycles elapse without fsm_out==IDLE_CODE, then at that edge done=1 and timeout=1 for one cycle, grant=0, ptr advances, go to IDLE.
- Undefined:
  - DRAIN waits indefinitely.
  - timeout is constant 0 and no drain counter is synthesized.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, HOLD=2'd1, DRAIN=2'd2);
  - the IDLE_CODE constant, shared with the Moore FSM's output encoding;
  - a default CW.
- One natural sub-module, rr_pick:
  - combinational circular priority select;
  - inputs req and ptr; outputs a one-hot selection and its index.

Test Plan:
- Reset then req=4'b0001, hold_len=3, fsm_out returns to 00 two cycles after bypass falls -> grant=0001 and bypass high 3 cycles, then DRAIN 2 cycles, then done pulse, then grant=0.
- req=4'b1111 held, fsm_out stuck at 00, hold_len=1 -> grants 0001, 0010, 0100, 1000, 0001 in order, each with bypass high 1 cycle and 1 IDLE cycle between.
- hold_len=0 -> bypass high exactly 1 cycle. hold_len=15 -> exactly 15 cycles.
- rst to 0 mid-HOLD (bypass=1) -> bypass, grant and busy drop to 0 immediately with no done. After release, ptr=0 so req=4'b1001 grants 0001.
- req[2] dropped mid-HOLD -> window completes full length and done still pulses.
- With BYPASS_ARB_TIMEOUT_EN, fsm_out stuck at 2'b11 -> done and timeout pulse together after 16 DRAIN cycles and ptr advances. Without the macro, DRAIN persists and timeout stays 0.
